// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates an instruction-fetch read port and a data
// read/write port onto one classic Wishbone master.
//
// Ports:
//   i_clk, i_reset_n            clock, synchronous active-low reset
//   i_ireq_* / o_ireq_ready     fetch request (read only), one-cycle accept pulse
//   o_iresp_*                   fetch response pulse, error flag, held read data
//   i_dreq_* / o_dreq_ready     data request (read/write), one-cycle accept pulse
//   o_dresp_*                   data response pulse, error flag, held read data
//   o_bus_* / i_bus_*           Wishbone master signals, o_bus_cachable for the region
//   o_busy                      high whenever a transaction is in progress
//
// Address map (upper bounds exclusive):
//   < 0x2000_0000 RAM (cachable), < 0x2800_0000 CSR, < 0x3000_0000 UART,
//   < 0x3800_0000 VGA/GPIO, < 0x4000_0000 QSPI, everything above is unmapped.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,

  input  logic        i_ireq_valid,
  input  logic [31:0] i_ireq_addr,
  output logic        o_ireq_ready,
  output logic        o_iresp_valid,
  output logic        o_iresp_err,
  output logic [31:0] o_iresp_data,

  input  logic        i_dreq_valid,
  input  logic        i_dreq_we,
  input  logic [31:0] i_dreq_addr,
  input  logic [31:0] i_dreq_wdata,
  input  logic [3:0]  i_dreq_sel,
  output logic        o_dreq_ready,
  output logic        o_dresp_valid,
  output logic        o_dresp_err,
  output logic [31:0] o_dresp_data,

  output logic        o_bus_cyc,
  output logic        o_bus_stb,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_data,
  output logic [3:0]  o_bus_sel,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_data,
  output logic        o_bus_cachable,
  output logic        o_busy
);

  localparam logic [31:0] RamEnd    = 32'h2000_0000;
  localparam logic [31:0] MappedEnd = 32'h4000_0000;

  // Counter only needs to reach TIMEOUT-1: the cycle that would make it
  // TIMEOUT is the one that fires the timeout.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBus, StErr} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_data_q, last_data_d;  // last grant went to the data port
  logic            port_data_q, port_data_d;  // current transaction owner
  logic            bus_we_q, bus_we_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [31:0]     bus_data_q, bus_data_d;
  logic [3:0]      bus_sel_q, bus_sel_d;
  logic            cach_q, cach_d;
  logic            iresp_valid_q, iresp_valid_d;
  logic            iresp_err_q, iresp_err_d;
  logic [31:0]     iresp_data_q, iresp_data_d;
  logic            dresp_valid_q, dresp_valid_d;
  logic            dresp_err_q, dresp_err_d;
  logic [31:0]     dresp_data_q, dresp_data_d;

  logic        gnt_i, gnt_d;
  logic        req_we;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_sel;
  logic        req_mapped, req_cach;
  logic        resp_fire, resp_err, resp_to_data;
  logic [31:0] resp_data;

  // Arbitration: only in IDLE and never while reset is held.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state_q == StIdle && i_reset_n) begin
      if (i_ireq_valid && i_dreq_valid) begin
        gnt_d = ~last_data_q;
        gnt_i = last_data_q;
      end else begin
        gnt_i = i_ireq_valid;
        gnt_d = i_dreq_valid;
      end
    end
  end

  // Fields of the winning request; fetches are always full-word reads.
  always_comb begin
    req_addr   = gnt_d ? i_dreq_addr : i_ireq_addr;
    req_we     = gnt_d & i_dreq_we;
    req_data   = gnt_d ? i_dreq_wdata : 32'h0;
    req_sel    = gnt_d ? i_dreq_sel : 4'hF;
    req_mapped = req_addr < MappedEnd;
    req_cach   = req_addr < RamEnd;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_data_d   = last_data_q;
    port_data_d   = port_data_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_data_d    = bus_data_q;
    bus_sel_d     = bus_sel_q;
    cach_d        = cach_q;
    iresp_valid_d = 1'b0;
    iresp_err_d   = 1'b0;
    iresp_data_d  = iresp_data_q;
    dresp_valid_d = 1'b0;
    dresp_err_d   = 1'b0;
    dresp_data_d  = dresp_data_q;
    resp_fire     = 1'b0;
    resp_err      = 1'b0;
    resp_data     = 32'h0;
    resp_to_data  = port_data_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_i || gnt_d) begin
          last_data_d = gnt_d;
          port_data_d = gnt_d;
          bus_we_d    = req_we;
          bus_addr_d  = req_addr;
          bus_data_d  = req_data;
          bus_sel_d   = req_sel;
          cach_d      = req_cach;
          cnt_d       = '0;
          if (req_mapped) begin
            state_d = StBus;
          end else begin
            state_d      = StErr;
            resp_fire    = 1'b1;
            resp_err     = 1'b1;
            resp_to_data = gnt_d;
          end
        end
      end
      StBus: begin
        // Ack is checked first so it wins against a simultaneous timeout.
        if (i_bus_ack) begin
          state_d   = StIdle;
          resp_fire = 1'b1;
          resp_data = bus_we_q ? 32'h0 : i_bus_data;
        end else if (cnt_q == CntLast) begin
          state_d   = StErr;
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (resp_fire) begin
      if (resp_to_data) begin
        dresp_valid_d = 1'b1;
        dresp_err_d   = resp_err;
        dresp_data_d  = resp_data;
      end else begin
        iresp_valid_d = 1'b1;
        iresp_err_d   = resp_err;
        iresp_data_d  = resp_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      last_data_q   <= 1'b0;
      port_data_q   <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'h0;
      bus_data_q    <= 32'h0;
      bus_sel_q     <= 4'h0;
      cach_q        <= 1'b0;
      iresp_valid_q <= 1'b0;
      iresp_err_q   <= 1'b0;
      iresp_data_q  <= 32'h0;
      dresp_valid_q <= 1'b0;
      dresp_err_q   <= 1'b0;
      dresp_data_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_data_q   <= last_data_d;
      port_data_q   <= port_data_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_data_q    <= bus_data_d;
      bus_sel_q     <= bus_sel_d;
      cach_q        <= cach_d;
      iresp_valid_q <= iresp_valid_d;
      iresp_err_q   <= iresp_err_d;
      iresp_data_q  <= iresp_data_d;
      dresp_valid_q <= dresp_valid_d;
      dresp_err_q   <= dresp_err_d;
      dresp_data_q  <= dresp_data_d;
    end
  end

  assign o_ireq_ready   = gnt_i;
  assign o_dreq_ready   = gnt_d;
  assign o_iresp_valid  = iresp_valid_q;
  assign o_iresp_err    = iresp_err_q;
  assign o_iresp_data   = iresp_data_q;
  assign o_dresp_valid  = dresp_valid_q;
  assign o_dresp_err    = dresp_err_q;
  assign o_dresp_data   = dresp_data_q;
  assign o_bus_cyc      = (state_q == StBus);
  assign o_bus_stb      = (state_q == StBus);
  assign o_bus_we       = bus_we_q;
  assign o_bus_addr     = bus_addr_q;
  assign o_bus_data     = bus_data_q;
  assign o_bus_sel      = bus_sel_q;
  assign o_bus_cachable = cach_q;
  assign o_busy         = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 4;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_ireq_valid;
  logic [31:0] i_ireq_addr;
  logic        o_ireq_ready;
  logic        o_iresp_valid;
  logic        o_iresp_err;
  logic [31:0] o_iresp_data;
  logic        i_dreq_valid;
  logic        i_dreq_we;
  logic [31:0] i_dreq_addr;
  logic [31:0] i_dreq_wdata;
  logic [3:0]  i_dreq_sel;
  logic        o_dreq_ready;
  logic        o_dresp_valid;
  logic        o_dresp_err;
  logic [31:0] o_dresp_data;
  logic        o_bus_cyc;
  logic        o_bus_stb;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_data;
  logic [3:0]  o_bus_sel;
  logic        i_bus_ack;
  logic [31:0] i_bus_data;
  logic        o_bus_cachable;
  logic        o_busy;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_ireq_valid  (i_ireq_valid),
    .i_ireq_addr   (i_ireq_addr),
    .o_ireq_ready  (o_ireq_ready),
    .o_iresp_valid (o_iresp_valid),
    .o_iresp_err   (o_iresp_err),
    .o_iresp_data  (o_iresp_data),
    .i_dreq_valid  (i_dreq_valid),
    .i_dreq_we     (i_dreq_we),
    .i_dreq_addr   (i_dreq_addr),
    .i_dreq_wdata  (i_dreq_wdata),
    .i_dreq_sel    (i_dreq_sel),
    .o_dreq_ready  (o_dreq_ready),
    .o_dresp_valid (o_dresp_valid),
    .o_dresp_err   (o_dresp_err),
    .o_dresp_data  (o_dresp_data),
    .o_bus_cyc     (o_bus_cyc),
    .o_bus_stb     (o_bus_stb),
    .o_bus_we      (o_bus_we),
    .o_bus_addr    (o_bus_addr),
    .o_bus_data    (o_bus_data),
    .o_bus_sel     (o_bus_sel),
    .i_bus_ack     (i_bus_ack),
    .i_bus_data    (i_bus_data),
    .o_bus_cachable(o_bus_cachable),
    .o_busy        (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: one in-flight bus transaction, or a one-cycle
  // turnaround after an error, plus the response each port should see next.
  bit          m_inflight = 1'b0;
  bit          m_turn     = 1'b0;
  bit          m_port_d   = 1'b0;
  bit          m_last_d   = 1'b0;
  bit          m_we       = 1'b0;
  logic [31:0] m_addr     = 32'h0;
  logic [31:0] m_wdata    = 32'h0;
  logic [3:0]  m_sel      = 4'h0;
  int          m_waited   = 0;
  bit          e_iv = 1'b0, e_ie = 1'b0, e_dv = 1'b0, e_de = 1'b0;
  logic [31:0] e_id = 32'h0, e_dd = 32'h0;

  task automatic model_respond(input bit to_d, input bit err, input logic [31:0] data);
    if (to_d) begin
      e_dv = 1'b1; e_de = err; e_dd = data;
    end else begin
      e_iv = 1'b1; e_ie = err; e_id = data;
    end
  endtask

  always @(negedge i_clk) begin
    bit free, gi, gd;
    free = i_reset_n && !m_inflight && !m_turn;
    gi = free && i_ireq_valid && (!i_dreq_valid || m_last_d);
    gd = free && i_dreq_valid && (!i_ireq_valid || !m_last_d);

    chk1("ireq_ready", o_ireq_ready, gi);
    chk1("dreq_ready", o_dreq_ready, gd);
    chk1("bus_cyc", o_bus_cyc, m_inflight);
    chk1("bus_stb", o_bus_stb, m_inflight);
    chk1("busy", o_busy, m_inflight || m_turn);
    chk1("iresp_valid", o_iresp_valid, e_iv);
    chk1("iresp_err", o_iresp_err, e_ie);
    chk32("iresp_data", o_iresp_data, e_id);
    chk1("dresp_valid", o_dresp_valid, e_dv);
    chk1("dresp_err", o_dresp_err, e_de);
    chk32("dresp_data", o_dresp_data, e_dd);
    chk1("one_resp", o_iresp_valid & o_dresp_valid, 1'b0);
    if (m_inflight) begin
      chk1("bus_we", o_bus_we, m_we);
      chk32("bus_addr", o_bus_addr, m_addr);
      chk32("bus_sel", {28'h0, o_bus_sel}, {28'h0, m_sel});
      chk1("bus_cachable", o_bus_cachable, m_addr < 32'h2000_0000);
      if (m_we) chk32("bus_data", o_bus_data, m_wdata);
    end

    // Advance the model to what the next cycle must show.
    if (!i_reset_n) begin
      m_inflight = 1'b0; m_turn = 1'b0; m_last_d = 1'b0; m_waited = 0;
      e_iv = 1'b0; e_ie = 1'b0; e_id = 32'h0;
      e_dv = 1'b0; e_de = 1'b0; e_dd = 32'h0;
    end else begin
      e_iv = 1'b0; e_ie = 1'b0; e_dv = 1'b0; e_de = 1'b0;
      if (m_inflight) begin
        if (i_bus_ack) begin
          model_respond(m_port_d, 1'b0, m_we ? 32'h0 : i_bus_data);
          m_inflight = 1'b0;
        end else begin
          m_waited++;
          if (m_waited == int'(TO)) begin
            model_respond(m_port_d, 1'b1, 32'h0);
            m_inflight = 1'b0;
            m_turn     = 1'b1;
          end
        end
      end else if (m_turn) begin
        m_turn = 1'b0;
      end else if (gi || gd) begin
        m_port_d = gd;
        m_last_d = gd;
        m_addr   = gd ? i_dreq_addr : i_ireq_addr;
        m_we     = gd && i_dreq_we;
        m_wdata  = i_dreq_wdata;
        m_sel    = gd ? i_dreq_sel : 4'hF;
        if (m_addr >= 32'h4000_0000) begin
          model_respond(gd, 1'b1, 32'h0);
          m_turn = 1'b1;
        end else begin
          m_inflight = 1'b1;
          m_waited   = 0;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [0:7];
    logic [31:0] r;
    edges = '{32'h0000_0000, 32'h1FFF_FFFF, 32'h2000_0000, 32'h27FF_FFFF,
              32'h37FF_FFFF, 32'h3FFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF};
    r = $urandom;
    case ($urandom_range(0, 7))
      0, 1:    return r & 32'h1FFF_FFFF;
      2:       return 32'h2000_0000 + (r & 32'h07FF_FFFF);
      3:       return 32'h2800_0000 + (r & 32'h07FF_FFFF);
      4:       return 32'h3000_0000 + (r & 32'h0FFF_FFFF);
      5:       return 32'h4000_0000 | r;
      default: return edges[$urandom_range(0, 7)];
    endcase
  endfunction

  bit prev_d, saw_i, saw_d;
  int grants, resps;

  initial begin
    i_reset_n = 1'b0; i_ireq_valid = 1'b0; i_ireq_addr = 32'h0;
    i_dreq_valid = 1'b0; i_dreq_we = 1'b0; i_dreq_addr = 32'h0;
    i_dreq_wdata = 32'h0; i_dreq_sel = 4'h0; i_bus_ack = 1'b0; i_bus_data = 32'h0;
    repeat (2) next_cycle();

    // Reset held with both ports requesting: nothing may be accepted.
    i_ireq_valid = 1'b1; i_ireq_addr = 32'h2800_0004;
    i_dreq_valid = 1'b1; i_dreq_we = 1'b0; i_dreq_addr = 32'h0000_0100; i_dreq_sel = 4'hF;
    @(negedge i_clk);
    chk1("rst_iready", o_ireq_ready, 1'b0);
    chk1("rst_dready", o_dreq_ready, 1'b0);
    chk1("rst_cyc", o_bus_cyc, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);

    // First tie after reset goes to the data port; RAM read is cachable.
    next_cycle(); i_reset_n = 1'b1;
    @(negedge i_clk);
    chk1("a_dready", o_dreq_ready, 1'b1);
    chk1("a_iready", o_ireq_ready, 1'b0);
    next_cycle(); i_dreq_valid = 1'b0;
    @(negedge i_clk);
    chk1("a_cyc", o_bus_cyc, 1'b1);
    chk1("a_cach", o_bus_cachable, 1'b1);
    chk32("a_addr", o_bus_addr, 32'h0000_0100);
    next_cycle(); i_bus_ack = 1'b1; i_bus_data = 32'h1234_5678;
    @(negedge i_clk);
    next_cycle(); i_bus_ack = 1'b0;
    @(negedge i_clk);
    chk1("a_dresp_valid", o_dresp_valid, 1'b1);
    chk32("a_dresp_data", o_dresp_data, 32'h1234_5678);
    chk1("a_cyc_drop", o_bus_cyc, 1'b0);
    chk1("a_iready_next", o_ireq_ready, 1'b1);

    // Fetch from CSR space, acked after three waiting cycles.
    next_cycle(); i_ireq_valid = 1'b0;
    @(negedge i_clk);
    chk1("b_cyc", o_bus_cyc, 1'b1);
    chk1("b_cach", o_bus_cachable, 1'b0);
    chk32("b_addr", o_bus_addr, 32'h2800_0004);
    chk32("b_sel", {28'h0, o_bus_sel}, 32'hF);
    repeat (2) begin next_cycle(); @(negedge i_clk); end
    next_cycle(); i_bus_ack = 1'b1; i_bus_data = 32'hDEAD_BEEF;
    @(negedge i_clk);
    next_cycle(); i_bus_ack = 1'b0;
    @(negedge i_clk);
    chk1("b_iresp_valid", o_iresp_valid, 1'b1);
    chk1("b_iresp_err", o_iresp_err, 1'b0);
    chk32("b_iresp_data", o_iresp_data, 32'hDEAD_BEEF);

    // Write to unmapped space: immediate error, no bus cycle.
    next_cycle();
    i_dreq_valid = 1'b1; i_dreq_we = 1'b1; i_dreq_addr = 32'h4000_0000;
    i_dreq_wdata = 32'hCAFE_F00D; i_dreq_sel = 4'h3;
    @(negedge i_clk);
    chk1("c_dready", o_dreq_ready, 1'b1);
    next_cycle(); i_dreq_valid = 1'b0;
    @(negedge i_clk);
    chk1("c_cyc", o_bus_cyc, 1'b0);
    chk1("c_dresp_valid", o_dresp_valid, 1'b1);
    chk1("c_dresp_err", o_dresp_err, 1'b1);
    chk32("c_dresp_data", o_dresp_data, 32'h0);
    chk1("c_busy", o_busy, 1'b1);
    next_cycle();
    @(negedge i_clk);
    chk1("c_busy_clear", o_busy, 1'b0);
    chk1("c_dresp_clear", o_dresp_valid, 1'b0);

    // Timeout: four bus cycles without ack, then error; late ack ignored.
    next_cycle(); i_ireq_valid = 1'b1; i_ireq_addr = 32'h0000_1000;
    @(negedge i_clk);
    chk1("d_iready", o_ireq_ready, 1'b1);
    next_cycle(); i_ireq_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk1("d_cyc_held", o_bus_cyc, 1'b1);
      next_cycle();
    end
    i_bus_ack = 1'b1;
    @(negedge i_clk);
    chk1("d_cyc_drop", o_bus_cyc, 1'b0);
    chk1("d_iresp_valid", o_iresp_valid, 1'b1);
    chk1("d_iresp_err", o_iresp_err, 1'b1);
    chk32("d_iresp_data", o_iresp_data, 32'h0);
    next_cycle();
    @(negedge i_clk);
    chk1("d_late_i", o_iresp_valid, 1'b0);
    chk1("d_late_d", o_dresp_valid, 1'b0);
    next_cycle(); i_bus_ack = 1'b0;
    @(negedge i_clk);
    chk1("d_late2_i", o_iresp_valid, 1'b0);

    // Reset in the middle of a bus cycle.
    next_cycle();
    i_ireq_valid = 1'b1; i_ireq_addr = 32'h0000_0200;
    i_dreq_valid = 1'b1; i_dreq_we = 1'b0; i_dreq_addr = 32'h3000_0010; i_dreq_sel = 4'hF;
    @(negedge i_clk);
    chk1("e_dready", o_dreq_ready, 1'b1);
    next_cycle(); i_dreq_valid = 1'b0;
    @(negedge i_clk);
    chk1("e_cyc", o_bus_cyc, 1'b1);
    next_cycle(); i_reset_n = 1'b0;
    @(negedge i_clk);
    next_cycle();
    @(negedge i_clk);
    chk1("e_rst_cyc", o_bus_cyc, 1'b0);
    chk1("e_rst_busy", o_busy, 1'b0);
    chk1("e_rst_iready", o_ireq_ready, 1'b0);
    chk1("e_rst_dresp", o_dresp_valid, 1'b0);
    chk32("e_rst_addr", o_bus_addr, 32'h0);
    chk32("e_rst_idata", o_iresp_data, 32'h0);
    next_cycle(); i_reset_n = 1'b1; i_bus_ack = 1'b1; i_dreq_valid = 1'b1;
    @(negedge i_clk);
    chk1("e_first_d", o_dreq_ready, 1'b1);
    chk1("e_first_i", o_ireq_ready, 1'b0);
    chk1("e_no_dresp", o_dresp_valid, 1'b0);

    // Both ports continuously requesting with a fast slave: grants alternate.
    grants = 0; resps = 0; saw_i = 1'b0; saw_d = 1'b1; prev_d = 1'b1;
    for (int c = 0; c < 60 && grants < 10; c++) begin
      next_cycle();
      i_bus_ack = 1'b1; i_bus_data = $urandom;
      if (saw_i) i_ireq_addr = $urandom & 32'h3FFF_FFFF;
      if (saw_d) begin
        i_dreq_addr = $urandom & 32'h3FFF_FFFF; i_dreq_we = 1'($urandom);
        i_dreq_wdata = $urandom; i_dreq_sel = 4'($urandom);
      end
      i_ireq_valid = 1'b1; i_dreq_valid = 1'b1;
      @(negedge i_clk);
      if (grants > 0 && (o_iresp_valid || o_dresp_valid)) resps++;
      saw_i = o_ireq_ready; saw_d = o_dreq_ready;
      if (saw_i || saw_d) begin
        if (grants > 0) chk1("f_alternate", saw_d, !prev_d);
        prev_d = saw_d;
        grants++;
      end
    end
    chk32("f_grants", grants, 10);
    for (int c = 0; c < 4; c++) begin
      next_cycle(); i_ireq_valid = 1'b0; i_dreq_valid = 1'b0;
      @(negedge i_clk);
      if (o_iresp_valid || o_dresp_valid) resps++;
    end
    chk32("f_resps", resps, 10);

    // Randomized traffic, including stray acks, timeouts and occasional reset.
    saw_i = 1'b0; saw_d = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      i_reset_n = ($urandom_range(0, 149) != 0);
      if (!i_ireq_valid || saw_i) begin
        i_ireq_valid = ($urandom_range(0, 9) < 5);
        i_ireq_addr  = rand_addr();
      end
      if (!i_dreq_valid || saw_d) begin
        i_dreq_valid = ($urandom_range(0, 9) < 5);
        i_dreq_addr  = rand_addr();
        i_dreq_we    = 1'($urandom);
        i_dreq_wdata = $urandom;
        i_dreq_sel   = 4'($urandom);
      end
      i_bus_ack  = ($urandom_range(0, 9) < 3);
      i_bus_data = $urandom;
      @(negedge i_clk);
      saw_i = o_ireq_ready; saw_d = o_dreq_ready;
    end

    next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
